// File: rtl/logic_arbiter.sv
// logic_arbiter: two-requester arbiter feeding a single registered 32-bit
// logic unit (nor/and/or/xor). IDLE -> EXEC -> RESP, one op per 3 cycles
// with the response consumer always ready.
// Optional build macro: LOGIC_ARB_FIXED_PRIO_EN (requester 0 always wins
// contention; the round-robin last_grant register is removed).
module logic_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  input  logic [1:0]  op0,
  input  logic [1:0]  op1,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_out,
  output logic [15:0] ops_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_NOR = 2'b00,
    OP_AND = 2'b01,
    OP_OR  = 2'b10,
    OP_XOR = 2'b11
  } op_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [1:0]  op_q;
  logic        id_q;
  logic [15:0] done_cnt;
  logic        grant_id;
  logic        accept;
  logic        resp_fire;

`ifndef LOGIC_ARB_FIXED_PRIO_EN
  logic        last_grant;
`endif

  function automatic logic [31:0] logic_op(input logic [1:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    case (op_t'(op))
      OP_NOR:  logic_op = ~(a | b);
      OP_AND:  logic_op = a & b;
      OP_OR:   logic_op = a | b;
      default: logic_op = a ^ b;
    endcase
  endfunction

  assign accept     = (state == IDLE) && (|req_valid);
  assign resp_valid = (state == RESP);
  assign resp_fire  = resp_valid && resp_ready;
  assign ops_done   = done_cnt;

  // Pick the winner among the currently valid requesters.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    grant_id = 1'b0;
    case (req_valid)
      2'b10: grant_id = 1'b1;
`ifdef LOGIC_ARB_FIXED_PRIO_EN
      2'b11: grant_id = 1'b0;
`else
      2'b11: grant_id = ~last_grant;
`endif
      default: grant_id = 1'b0;
    endcase
  end

  // Next-state and combinational ready for the winning requester.
  always_comb begin
    state_nxt = state;
    req_ready = 2'b00;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          req_ready[grant_id] = 1'b1;
          state_nxt           = EXEC;
        end
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset wins over any handshake on the same edge.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Capture the winning requester's operands on the accept edge.
  always_ff @(posedge clk) begin
    // NOTE: pure data holding registers are left unreset; they are only read after being loaded.
    if (accept) begin
      a_q  <= grant_id ? a1  : a0;
      b_q  <= grant_id ? b1  : b0;
      op_q <= grant_id ? op1 : op0;
      id_q <= grant_id;
    end
  end

  // Evaluate the captured operation in EXEC; hold it through RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_out <= 32'd0;
      resp_id  <= 1'b0;
    end else if (state == EXEC) begin
      resp_out <= logic_op(op_q, a_q, b_q);
      resp_id  <= id_q;
    end
  end

  // Count completed responses; wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst)            done_cnt <= 16'd0;
    else if (resp_fire) done_cnt <= done_cnt + 16'd1;
  end

`ifndef LOGIC_ARB_FIXED_PRIO_EN
  // Remember who was served last so contention alternates; 1 after reset so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (rst)            last_grant <= 1'b1;
    else if (resp_fire) last_grant <= resp_id;
  end
`endif

endmodule

// File: tb/tb_logic_arbiter.sv
// tb_logic_arbiter: directed bench for logic_arbiter.
// Inputs change and outputs are sampled on the falling edge.
module tb_logic_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] a0, b0, a1, b1;
  logic [1:0]  op0, op1;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_id;
  logic [31:0] resp_out;
  logic [15:0] ops_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  logic_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .a0         (a0),
    .b0         (b0),
    .a1         (a1),
    .b1         (b1),
    .op0        (op0),
    .op1        (op1),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_out   (resp_out),
    .ops_done   (ops_done)
  );

  // Advance one rising edge, then return on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req_valid = 2'b00; resp_ready = 1'b1;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; op0 = '0; op1 = '0;
    do_reset();
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
    checks++; if (resp_out !== 32'd0) begin errors++; $display("FAIL reset_resp_out got %h want 0", resp_out); end
    checks++; if (resp_id !== 1'b0) begin errors++; $display("FAIL reset_resp_id got %b want 0", resp_id); end
    checks++; if (ops_done !== 16'd0) begin errors++; $display("FAIL reset_ops_done got %h want 0", ops_done); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b want 00", req_ready); end
  endtask

  task automatic test_logic_ops();
    logic [31:0] exp_tab [4];
    exp_tab[0] = 32'hFFFF_FFF1; exp_tab[1] = 32'h0000_0008;
    exp_tab[2] = 32'h0000_000E; exp_tab[3] = 32'h0000_0006;
    a0 = 32'hA; b0 = 32'hC; resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      op0 = 2'(i); req_valid = 2'b01;
      #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL op%0d_req_ready got %b want 01", i, req_ready); end
      step();
      req_valid = 2'b00;
      checks++; if (resp_valid !== 1'b0 || req_ready !== 2'b00) begin errors++; $display("FAIL op%0d_exec got v=%b r=%b want v=0 r=00", i, resp_valid, req_ready); end
      step();
      checks++; if (resp_valid !== 1'b1 || resp_id !== 1'b0) begin errors++; $display("FAIL op%0d_resp got v=%b id=%b want v=1 id=0", i, resp_valid, resp_id); end
      checks++; if (resp_out !== exp_tab[i]) begin errors++; $display("FAIL op%0d_result got %h want %h", i, resp_out, exp_tab[i]); end
      step();
      checks++; if (ops_done !== 16'(i + 1) || resp_valid !== 1'b0) begin errors++; $display("FAIL op%0d_done got cnt=%h v=%b want cnt=%h v=0", i, ops_done, resp_valid, 16'(i + 1)); end
    end
  endtask

  task automatic test_round_robin();
    logic exp_id [4];
`ifdef LOGIC_ARB_FIXED_PRIO_EN
    exp_id[0] = 1'b0; exp_id[1] = 1'b0; exp_id[2] = 1'b0; exp_id[3] = 1'b0;
`else
    exp_id[0] = 1'b0; exp_id[1] = 1'b1; exp_id[2] = 1'b0; exp_id[3] = 1'b1;
`endif
    do_reset();
    a0 = 32'h0000_00FA; b0 = 32'h0000_000C; op0 = 2'b01;
    a1 = 32'hF0F0_0000; b1 = 32'h0F0F_FFFF; op1 = 2'b11;
    req_valid = 2'b11; resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (req_ready !== (exp_id[i] ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr%0d_grant got %b want id %0d", i, req_ready, exp_id[i]); end
      step();
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rr%0d_exec_ready got %b want 00", i, req_ready); end
      step();
      checks++; if (resp_id !== exp_id[i] || resp_out !== (exp_id[i] ? 32'hFFFF_FFFF : 32'h0000_0008)) begin
        errors++; $display("FAIL rr%0d_resp got id=%b out=%h want id=%b", i, resp_id, resp_out, exp_id[i]);
      end
      step();
    end
    req_valid = 2'b00;
    checks++; if (ops_done !== 16'd4) begin errors++; $display("FAIL rr_ops_done got %h want 4", ops_done); end
  endtask

  task automatic test_backpressure();
    do_reset();
    a1 = 32'h5; b1 = 32'h3; op1 = 2'b10; a0 = 32'h1; b0 = 32'h1; op0 = 2'b11;
    resp_ready = 1'b0; req_valid = 2'b10;
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL bp_single_grant got %b want 10", req_ready); end
    step();
    a1 = 32'hFFFF_FFFF; op1 = 2'b00; req_valid = 2'b11;
    step();
    a0 = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      checks++; if (resp_valid !== 1'b1 || resp_out !== 32'h7 || resp_id !== 1'b1 || req_ready !== 2'b00) begin
        errors++; $display("FAIL bp_hold%0d got v=%b out=%h id=%b r=%b want v=1 out=7 id=1 r=00", i, resp_valid, resp_out, resp_id, req_ready);
      end
      step();
    end
    resp_ready = 1'b1;
    step();
    checks++; if (ops_done !== 16'd1 || resp_valid !== 1'b0) begin errors++; $display("FAIL bp_release got cnt=%h v=%b want 1,0", ops_done, resp_valid); end
`ifdef LOGIC_ARB_FIXED_PRIO_EN
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_next_grant got %b want 01", req_ready); end
`else
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_next_grant got %b want 01", req_ready); end
`endif
    req_valid = 2'b00;
    step(); step(); step();
  endtask

  task automatic test_reset_abort();
    do_reset();
    a0 = 32'hA; b0 = 32'hC; op0 = 2'b00; resp_ready = 1'b1; req_valid = 2'b01;
    step(); req_valid = 2'b00; step(); step();
    req_valid = 2'b11;
    #1;
`ifdef LOGIC_ARB_FIXED_PRIO_EN
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL abort_pre_grant got %b want 01", req_ready); end
`else
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL abort_pre_grant got %b want 10", req_ready); end
`endif
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++; if (resp_valid !== 1'b0 || ops_done !== 16'd0) begin errors++; $display("FAIL abort_exec got v=%b cnt=%h want 0,0", resp_valid, ops_done); end
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL abort_last_grant got %b want 01", req_ready); end
    step(); step();
    req_valid = 2'b00;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++; if (resp_valid !== 1'b0 || ops_done !== 16'd0) begin errors++; $display("FAIL abort_resp got v=%b cnt=%h want 0,0", resp_valid, ops_done); end
  endtask

  task automatic test_wrap();
    do_reset();
    force dut.done_cnt = 16'hFFFE;
    #1;
    release dut.done_cnt;
    a0 = 32'hA; b0 = 32'hC; op0 = 2'b11; resp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_valid = 2'b01;
      step(); req_valid = 2'b00; step(); step();
      checks++; if (ops_done !== (i == 0 ? 16'hFFFF : 16'h0000)) begin
        errors++; $display("FAIL wrap%0d got %h want %h", i, ops_done, (i == 0 ? 16'hFFFF : 16'h0000));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_logic_ops();
    test_round_robin();
    test_backpressure();
    test_reset_abort();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
